// File: rtl/sim_data_mem.sv
// sim_data_mem: latency-configurable data memory for the simulation top.
// It runs on the free-running clock and is qualified by step_en. One request
// at a time travels IDLE -> WAIT -> RESP. The access commits on the edge that
// enters RESP.
// Optional build macro SIM_DATA_MEM_STATS_EN adds load/store/error counters.
module sim_data_mem #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy
`ifdef SIM_DATA_MEM_STATS_EN
    ,
    output logic [31:0]           stat_loads,
    output logic [31:0]           stat_stores,
    output logic [31:0]           stat_errors
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    // Byte span of the array, kept wide so the range check cannot wrap.
    localparam logic [63:0]       SPAN       = 64'(DEPTH) * 64'(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Word storage. The C++ harness reads and writes this array directly by name.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BYTES-1:0]   be_q, be_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rerr_q, rerr_d;

    logic [ADDR_W-1:0]  addr_off;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;

    logic               commit;
    logic               mem_we;
    logic               cm_write;
    logic [IDX_W-1:0]   cm_idx;
    logic [DATA_W-1:0]  cm_wdata;
    logic [BYTES-1:0]   cm_be;
    logic               cm_err;
    logic [DATA_W-1:0]  rd_word;

    // Decode the incoming byte address into a word index and a fault flag.
    always_comb begin
        addr_off = req_addr - BASE_ADDR;
        req_err  = (req_addr < BASE_ADDR)
                || (64'(addr_off) >= SPAN)
                || ((req_addr & ALIGN_MASK) != '0);
        req_idx  = IDX_W'(addr_off >> OFF_W);
    end

    // Pick the operands of the access being committed. With LATENCY = 1 the
    // commit happens on the accept edge, so the live request is used.
    always_comb begin
        if (state_q == S_IDLE) begin
            cm_write = req_write;
            cm_idx   = req_idx;
            cm_wdata = req_wdata;
            cm_be    = req_be;
            cm_err   = req_err;
        end else begin
            cm_write = write_q;
            cm_idx   = idx_q;
            cm_wdata = wdata_q;
            cm_be    = be_q;
            cm_err   = err_q;
        end
        rd_word = mem[cm_idx];
    end

    // Next-state logic: accept, count down the latency, commit, release.
    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_err;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            rdata_d = (cm_write || cm_err) ? '0 : rd_word;
            rerr_d  = cm_err;
        end
    end

    // Outputs depend on the state register only. This keeps resp_ready and
    // req_* out of any combinational path to the outputs.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_RESP);
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

    // State register: synchronous reset, otherwise advance only when step_en is high.
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // sample their next value together at the edge, and no register sees a
    // half-updated neighbour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (step_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    assign mem_we = commit && step_en && !reset && cm_write && !cm_err;

    // Byte-lane store on the commit edge.
    // NOTE: the array is deliberately outside reset. Reset must not erase
    // memory contents, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (cm_be[b]) begin
                    mem[cm_idx][b*8 +: 8] <= cm_wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef SIM_DATA_MEM_STATS_EN
    logic [31:0] stat_loads_q, stat_stores_q, stat_errors_q;

    // Access statistics, bumped on each commit edge and wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errors_q <= '0;
        end else if (step_en && commit) begin
            if (cm_err) begin
                stat_errors_q <= stat_errors_q + 32'd1;
            end else if (cm_write) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end else begin
                stat_loads_q  <= stat_loads_q + 32'd1;
            end
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errors = stat_errors_q;
`endif

endmodule
